alarm_set_ctrl: RTL and testbench

//  Button-driven sequencer for the alarm clock datapath: stages H/M digits, issues

---
 rtl/alarm_set_ctrl.sv | 141 ++++++++++++++
 tb/tb_alarm_set_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_set_ctrl.sv
// alarm_set_ctrl: button sequencer staging H/M digits and issuing load_time/load_alarm/stop_al pulses
module alarm_set_ctrl #(
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int TIMEOUT_CYC = 600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       btn_snooze,
  input  logic       alarm_active,
  input  logic [1:0] cur_h1,
  input  logic [3:0] cur_h0,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m0,
  input  logic [1:0] al_h1,
  input  logic [3:0] al_h0,
  input  logic [3:0] al_m1,
  input  logic [3:0] al_m0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       load_time,
  output logic       load_alarm,
  output logic       stop_al,
  output logic [1:0] edit_mode,
  output logic [1:0] cursor,
  output logic [1:0] snooze_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, SET_T, SET_A, COMMIT_T, COMMIT_A, SNZ_STOP, SNZ_LOAD} state_t;
  state_t state, nstate;
  logic [TW-1:0] tcnt, n_tc;
  logic [1:0] n_h1, n_cur, n_snz, i_h1;
  logic [3:0] n_h0, n_m1, n_m0, i_h0, i_m1, i_m0;
  logic [6:0] cm, sm, ch, sh;
  logic mw, any_btn;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      tcnt <= '0;
      H_in1 <= '0;
      H_in0 <= '0;
      M_in1 <= '0;
      M_in0 <= '0;
      cursor <= '0;
      snooze_cnt <= '0;
    end else begin
      state <= nstate;
      tcnt <= n_tc;
      H_in1 <= n_h1;
      H_in0 <= n_h0;
      M_in1 <= n_m1;
      M_in0 <= n_m0;
      cursor <= n_cur;
      snooze_cnt <= n_snz;
    end
  // snooze target: current time plus SNOOZE_MIN, wrapping past 23:59
  always_comb begin
    cm = 7'(cur_m1) * 7'd10 + 7'(cur_m0) + 7'(SNOOZE_MIN);
    mw = cm >= 7'd60;
    sm = mw ? cm - 7'd60 : cm;
    ch = 7'(cur_h1) * 7'd10 + 7'(cur_h0) + 7'(mw);
    sh = ch >= 7'd24 ? ch - 7'd24 : ch;
  end
  always_comb begin
    i_h1 = H_in1 == 2'd2 ? 2'd0 : H_in1 + 2'd1;
    i_h0 = H_in0 >= (H_in1 == 2'd2 ? 4'd3 : 4'd9) ? 4'd0 : H_in0 + 4'd1;
    i_m1 = M_in1 >= 4'd5 ? 4'd0 : M_in1 + 4'd1;
    i_m0 = M_in0 >= 4'd9 ? 4'd0 : M_in0 + 4'd1;
  end
  always_comb begin
    nstate = state;
    n_tc = '0;
    n_h1 = H_in1;
    n_h0 = H_in0;
    n_m1 = M_in1;
    n_m0 = M_in0;
    n_cur = cursor;
    n_snz = snooze_cnt;
    any_btn = btn_mode | btn_next | btn_inc | btn_snooze;
    case (state)
      IDLE:
        if (btn_mode) begin
          nstate = SET_T;
          {n_h1, n_h0, n_m1, n_m0} = {cur_h1, cur_h0, cur_m1, cur_m0};
          n_cur = 2'd0;
        end else if (btn_snooze && alarm_active) nstate = SNZ_STOP;
      SET_T, SET_A: begin
        n_tc = any_btn ? '0 : tcnt + 1'b1;
        if (btn_mode) begin
          nstate = state == SET_T ? SET_A : IDLE;
          if (state == SET_T) {n_h1, n_h0, n_m1, n_m0} = {al_h1, al_h0, al_m1, al_m0};
          n_cur = 2'd0;
        end else if (btn_next) begin
          nstate = cursor == 2'd3 ? (state == SET_T ? COMMIT_T : COMMIT_A) : state;
          n_cur = cursor == 2'd3 ? cursor : cursor + 2'd1;
        end else if (btn_inc) begin
          if (cursor == 2'd0) begin
            n_h1 = i_h1;
            n_h0 = i_h1 == 2'd2 && H_in0 > 4'd3 ? 4'd3 : H_in0;
          end
          if (cursor == 2'd1) n_h0 = i_h0;
          if (cursor == 2'd2) n_m1 = i_m1;
          if (cursor == 2'd3) n_m0 = i_m0;
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          nstate = IDLE;
          n_tc = '0;
          n_cur = 2'd0;
        end
      end
      COMMIT_T: begin
        nstate = IDLE;
        n_cur = 2'd0;
      end
      COMMIT_A: begin
        nstate = IDLE;
        n_cur = 2'd0;
        n_snz = 2'd0;
      end
      SNZ_STOP:
        if (int'(snooze_cnt) < MAX_SNOOZE) begin
          nstate = SNZ_LOAD;
          n_h1 = 2'(sh / 7'd10);
          n_h0 = 4'(sh % 7'd10);
          n_m1 = 4'(sm / 7'd10);
          n_m0 = 4'(sm % 7'd10);
          n_snz = snooze_cnt + 2'd1;
        end else nstate = IDLE;
      SNZ_LOAD: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
  assign load_time = state == COMMIT_T;
  assign load_alarm = state == COMMIT_A || state == SNZ_LOAD;
  assign stop_al = state == SNZ_STOP;
  assign edit_mode = state == SET_T || state == COMMIT_T ? 2'd1 : state == SET_A || state == COMMIT_A ? 2'd2 : 2'd0;
endmodule

// File: tb/tb_alarm_set_ctrl.sv
// tb_alarm_set_ctrl: directed stimulus checked against a minute-arithmetic model every cycle
module tb_alarm_set_ctrl;
  localparam int SN = 5, MX = 3, TO = 600;
  localparam logic [3:0] M = 4'b1000, N = 4'b0100, I = 4'b0010, S = 4'b0001;
  logic clock = 0, reset = 1;
  logic btn_mode = 0, btn_next = 0, btn_inc = 0, btn_snooze = 0, alarm_active = 0;
  logic [1:0] cur_h1 = 0, al_h1 = 0;
  logic [3:0] cur_h0 = 0, cur_m1 = 0, cur_m0 = 0, al_h0 = 0, al_m1 = 0, al_m0 = 0;
  logic [1:0] H_in1, edit_mode, cursor, snooze_cnt;
  logic [3:0] H_in0, M_in1, M_in0;
  logic load_time, load_alarm, stop_al;
  int checks = 0, errors = 0;
  int md, cp, snz, idle, pulse;
  int d[4];
  logic [22:0] exp_v, dut_v;
  always #5 clock = ~clock;
  alarm_set_ctrl #(.SNOOZE_MIN(SN), .MAX_SNOOZE(MX), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset), .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .btn_snooze(btn_snooze), .alarm_active(alarm_active),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .al_h1(al_h1), .al_h0(al_h0), .al_m1(al_m1), .al_m0(al_m0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .load_time(load_time), .load_alarm(load_alarm), .stop_al(stop_al),
    .edit_mode(edit_mode), .cursor(cursor), .snooze_cnt(snooze_cnt)
  );
  // pulse: 0 none, 1 time commit, 2 alarm commit, 3 stop, 4 snooze reload
  task automatic model_step();
    int t;
    bit any;
    any = btn_mode | btn_next | btn_inc | btn_snooze;
    if (pulse == 1 || pulse == 2) begin
      if (pulse == 2) snz = 0;
      md = 0; cp = 0; pulse = 0;
    end else if (pulse == 3) begin
      if (snz < MX) begin
        t = ((int'(cur_h1) * 10 + int'(cur_h0)) * 60 + int'(cur_m1) * 10 + int'(cur_m0) + SN) % 1440;
        d[0] = t / 600; d[1] = (t / 60) % 10; d[2] = (t % 60) / 10; d[3] = t % 10;
        snz++; pulse = 4;
      end else pulse = 0;
    end else if (pulse == 4) pulse = 0;
    else if (md == 0) begin
      if (btn_mode) begin
        md = 1; cp = 0; idle = 0;
        d[0] = int'(cur_h1); d[1] = int'(cur_h0); d[2] = int'(cur_m1); d[3] = int'(cur_m0);
      end else if (btn_snooze && alarm_active) pulse = 3;
    end else begin
      idle = any ? 0 : idle + 1;
      if (btn_mode) begin
        if (md == 1) begin
          d[0] = int'(al_h1); d[1] = int'(al_h0); d[2] = int'(al_m1); d[3] = int'(al_m0);
        end
        md = md == 1 ? 2 : 0; cp = 0;
      end else if (btn_next) begin
        if (cp == 3) pulse = md; else cp++;
      end else if (btn_inc) begin
        if (cp == 0) begin
          d[0] = (d[0] + 1) % 3;
          if (d[0] == 2 && d[1] > 3) d[1] = 3;
        end
        if (cp == 1) d[1] = (d[1] + 1) % (d[0] == 2 ? 4 : 10);
        if (cp == 2) d[2] = (d[2] + 1) % 6;
        if (cp == 3) d[3] = (d[3] + 1) % 10;
      end else if (idle == TO) begin
        md = 0; cp = 0; idle = 0;
      end
    end
  endtask
  always @(posedge clock or posedge reset)
    if (reset) begin
      md = 0; cp = 0; snz = 0; idle = 0; pulse = 0;
      for (int i = 0; i < 4; i++) d[i] = 0;
    end else model_step();
  assign dut_v = {H_in1, H_in0, M_in1, M_in0, load_time, load_alarm, stop_al, edit_mode, cursor, snooze_cnt};
  always @(negedge clock) begin
    exp_v = {2'(d[0]), 4'(d[1]), 4'(d[2]), 4'(d[3]), pulse == 1, pulse == 2 || pulse == 4, pulse == 3,
             2'(md), 2'(cp), 2'(snz)};
    checks++;
    if (dut_v !== exp_v) begin
      errors++;
      $display("FAIL model t=%0t got=%h exp=%h", $time, dut_v, exp_v);
    end
  end
  task automatic step(input logic [3:0] b);
    {btn_mode, btn_next, btn_inc, btn_snooze} = b;
    @(negedge clock);
    {btn_mode, btn_next, btn_inc, btn_snooze} = 4'b0;
  endtask
  task automatic chk(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, got, want);
    end
  endtask
  function automatic int stage();
    return int'({H_in1, H_in0, M_in1, M_in0});
  endfunction
  initial begin
    {cur_h1, cur_h0, cur_m1, cur_m0} = {2'd0, 4'd7, 4'd4, 4'd5};
    {al_h1, al_h0, al_m1, al_m0} = {2'd0, 4'd6, 4'd3, 4'd0};
    repeat (2) @(negedge clock);
    chk("rst_mode", int'(edit_mode), 0);
    chk("rst_pulses", int'({load_time, load_alarm, stop_al}), 0);
    chk("rst_stage", stage(), 0);
    reset = 0;
    step(M);
    chk("set_t_mode", int'(edit_mode), 1);
    chk("set_t_stage", stage(), 'h0745);
    step(I);
    #2 reset = 1;
    #1 chk("midrst_mode", int'(edit_mode), 0);
    chk("midrst_cursor", int'(cursor), 0);
    chk("midrst_stage", stage(), 0);
    @(negedge clock);
    reset = 0;
    step(M); step(I); step(I);
    chk("h1_clamp", stage(), 'h2345);
    repeat (3) step(N);
    chk("cursor_m0", int'(cursor), 3);
    step(I); step(N);
    chk("load_time", int'(load_time), 1);
    chk("lt_stage", stage(), 'h2346);
    chk("lt_excl", int'({load_alarm, stop_al}), 0);
    step(4'b0);
    chk("lt_once", int'(load_time), 0);
    chk("lt_idle", int'(edit_mode), 0);
    {cur_h1, cur_h0, cur_m1, cur_m0} = {2'd2, 4'd3, 4'd5, 4'd7};
    alarm_active = 1;
    step(S);
    chk("snz_stop", int'(stop_al), 1);
    chk("snz_stop_nl", int'(load_alarm), 0);
    step(4'b0);
    chk("snz_load", int'(load_alarm), 1);
    chk("snz_stage", stage(), 'h0002);
    chk("snz_cnt1", int'(snooze_cnt), 1);
    chk("snz_load_ns", int'(stop_al), 0);
    step(4'b0);
    repeat (2) begin step(S); step(4'b0); step(4'b0); end
    chk("snz_cnt3", int'(snooze_cnt), 3);
    step(S);
    chk("snz4_stop", int'(stop_al), 1);
    step(4'b0);
    chk("snz4_noload", int'(load_alarm), 0);
    chk("snz4_cnt", int'(snooze_cnt), 3);
    alarm_active = 0;
    step(S);
    chk("snz_inactive", int'(stop_al), 0);
    step(M); step(M);
    chk("set_a_mode", int'(edit_mode), 2);
    chk("set_a_stage", stage(), 'h0630);
    alarm_active = 1;
    step(S);
    chk("snz_in_edit", int'(stop_al), 0);
    alarm_active = 0;
    repeat (3) step(N);
    step(N);
    chk("load_alarm", int'(load_alarm), 1);
    chk("la_stage", stage(), 'h0630);
    step(4'b0);
    chk("la_cnt_clr", int'(snooze_cnt), 0);
    step(M);
    repeat (TO - 1) step(4'b0);
    chk("pre_timeout", int'(edit_mode), 1);
    step(4'b0);
    chk("timeout_idle", int'(edit_mode), 0);
    chk("timeout_nolt", int'(load_time), 0);
    step(M | I);
    chk("prio_mode1", int'(edit_mode), 1);
    chk("prio_stage1", stage(), 'h2357);
    step(M | I);
    chk("prio_mode2", int'(edit_mode), 2);
    chk("prio_stage2", stage(), 'h0630);
    step(N | I);
    chk("prio_next", int'(cursor), 1);
    chk("prio_noinc", stage(), 'h0630);
    step(M);
    chk("set_a_exit", int'(edit_mode), 0);
    step(4'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
